// File: rtl/data_mem_lsu_pkg.sv
// Shared load/store sizing definitions for the data memory LSU:
// access-size codes, read-stage control record, byte-enable and alignment helpers.
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic [2:0] lane;
    logic [1:0] size;
    logic       uns;
  } rd_ctl_t;

  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  // Only the three low address bits can make an access misaligned.
  function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (addr_lo[0] == 1'b0);
      SZ_W:    ok = (addr_lo[1:0] == 2'b00);
      default: ok = (addr_lo == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_lsu_load_align.sv
// Load alignment: shifts the addressed bytes of a raw memory word down to
// bit 0 and sign- or zero-extends them to the full data width.
module load_align
  import dm_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [D_WIDTH-1:0] raw_i,
  input  logic [2:0]         lane_i,
  input  logic [1:0]         size_i,
  input  logic               uns_i,
  output logic [D_WIDTH-1:0] data_o
);

  logic [D_WIDTH-1:0] sh_s;
  logic [D_WIDTH-1:0] mask_s;
  logic               sign_s;
  logic               ext_s;

  always_comb begin
    sh_s   = raw_i >> {lane_i, 3'b000};
    mask_s = '0;
    sign_s = 1'b0;
    case (size_i)
      SZ_B: begin
        mask_s[7:0] = '1;
        sign_s      = sh_s[7];
      end
      SZ_H: begin
        mask_s[15:0] = '1;
        sign_s       = sh_s[15];
      end
      SZ_W: begin
        mask_s[31:0] = '1;
        sign_s       = sh_s[31];
      end
      default: begin
        mask_s = '1;
        sign_s = 1'b0;
      end
    endcase
    ext_s  = sign_s & ~uns_i;
    data_o = (sh_s & mask_s) | ({D_WIDTH{ext_s}} & ~mask_s);
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with one write port and a pipelined read port:
// store byte enables, same-cycle write forwarding, fault detection and fault counting.
module data_mem_lsu
  import dm_pkg::*;
#(
  parameter int MEM_A_WIDTH = 8,
  parameter int D_WIDTH     = 32,
  parameter int RD_LAT      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w_en,
  input  logic [31:0]        w_addr,
  input  logic [1:0]         w_size,
  input  logic [D_WIDTH-1:0] w_data,
  output logic               w_err,
  input  logic               r_en,
  input  logic [31:0]        r_addr,
  input  logic [1:0]         r_size,
  input  logic               r_uns,
  output logic               r_valid,
  output logic [D_WIDTH-1:0] r_data,
  output logic               r_err,
  output logic [7:0]         err_cnt
);

  localparam int         NB     = D_WIDTH / 8;
  localparam int         OFF    = $clog2(NB);
  localparam int         DEPTH  = 2 ** MEM_A_WIDTH;
  localparam logic [1:0] MAX_SZ = 2'(OFF);

  logic [D_WIDTH-1:0]     mem_q [DEPTH];
  logic [MEM_A_WIDTH-1:0] w_idx_s, r_idx_s;
  logic [2:0]             w_lane_s, r_lane_s;
  logic                   w_fault_s, w_ok_s, r_fault_s, fwd_s;
  logic [7:0]             w_be8_s;
  logic [NB-1:0]          w_be_s;
  logic [D_WIDTH-1:0]     w_data_sh_s;
  logic [D_WIDTH-1:0]     s1_raw_d, s1_raw_q, fin_raw_s, align_s;
  rd_ctl_t                s1_ctl_d, s1_ctl_q, fin_ctl_s;
  logic [1:0]             err_inc_s;
  logic [8:0]             err_sum_s;
  logic [7:0]             err_cnt_d, err_cnt_q;
  logic                   w_err_d, w_err_q;
  logic                   addr_unused_s;

  assign w_idx_s     = w_addr[MEM_A_WIDTH+OFF-1:OFF];
  assign r_idx_s     = r_addr[MEM_A_WIDTH+OFF-1:OFF];
  assign w_lane_s    = 3'(w_addr[OFF-1:0]);
  assign r_lane_s    = 3'(r_addr[OFF-1:0]);
  assign w_fault_s   = w_en && ((w_size > MAX_SZ) || !is_aligned(w_addr[2:0], w_size));
  assign r_fault_s   = r_en && ((r_size > MAX_SZ) || !is_aligned(r_addr[2:0], r_size));
  assign w_ok_s      = w_en && !w_fault_s;
  assign w_be8_s     = be_mask(w_size, w_lane_s);
  assign w_be_s      = w_be8_s[NB-1:0];
  assign w_data_sh_s = w_data << {w_lane_s, 3'b000};
  assign fwd_s       = w_ok_s && (w_idx_s == r_idx_s);

  // Upper address bits alias onto the array by design.
  assign addr_unused_s = ^{w_addr[31:MEM_A_WIDTH+OFF], r_addr[31:MEM_A_WIDTH+OFF]};

  generate
    if (NB < 8) begin : g_be_narrow
      logic be_unused_s;
      assign be_unused_s = ^w_be8_s[7:NB];
    end
  endgenerate

  // Byte-masked array update; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ok_s) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be_s[b]) mem_q[w_idx_s][b*8 +: 8] <= w_data_sh_s[b*8 +: 8];
      end
    end
  end

  // Read issue: sample the array, merging any same-cycle write bytes over it.
  always_comb begin
    s1_raw_d = '0;
    if (r_en && !r_fault_s) begin
      for (int b = 0; b < NB; b++) begin
        s1_raw_d[b*8 +: 8] = (fwd_s && w_be_s[b]) ? w_data_sh_s[b*8 +: 8]
                                                  : mem_q[r_idx_s][b*8 +: 8];
      end
    end else begin
      s1_raw_d = '0;
    end
    s1_ctl_d = '{valid: r_en, err: r_fault_s, lane: r_lane_s, size: r_size, uns: r_uns};
  end

  always_comb begin
    err_inc_s = {1'b0, w_fault_s} + {1'b0, r_fault_s};
    err_sum_s = {1'b0, err_cnt_q} + {7'd0, err_inc_s};
    err_cnt_d = err_sum_s[8] ? 8'hFF : err_sum_s[7:0];
    w_err_d   = w_fault_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctl_q  <= '0;
      s1_raw_q  <= '0;
      err_cnt_q <= 8'd0;
      w_err_q   <= 1'b0;
    end else begin
      s1_ctl_q  <= s1_ctl_d;
      s1_raw_q  <= s1_raw_d;
      err_cnt_q <= err_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      rd_ctl_t            s2_ctl_q;
      logic [D_WIDTH-1:0] s2_raw_q;

      // Second read stage; the raw word is already captured so later writes cannot leak in.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_ctl_q <= '0;
          s2_raw_q <= '0;
        end else begin
          s2_ctl_q <= s1_ctl_q;
          s2_raw_q <= s1_raw_q;
        end
      end

      assign fin_ctl_s = s2_ctl_q;
      assign fin_raw_s = s2_raw_q;
    end else begin : g_lat1
      assign fin_ctl_s = s1_ctl_q;
      assign fin_raw_s = s1_raw_q;
    end
  endgenerate

  load_align #(.D_WIDTH(D_WIDTH)) u_load_align (
    .raw_i  (fin_raw_s),
    .lane_i (fin_ctl_s.lane),
    .size_i (fin_ctl_s.size),
    .uns_i  (fin_ctl_s.uns),
    .data_o (align_s)
  );

  // Faulting reads carry an all-zero raw word, so their data comes out as 0.
  assign r_valid = fin_ctl_s.valid;
  assign r_err   = fin_ctl_s.err;
  assign r_data  = align_s;
  assign w_err   = w_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench: three LSU configurations (32b/lat1, 32b/lat2, 64b/lat1) share stimulus;
// a vector table covers sizing/extension/faults, hand sequences cover multi-cycle cases.
module tb_data_mem_lsu;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_en, r_en, r_uns;
  logic [31:0] w_addr, r_addr;
  logic [1:0]  w_size, r_size;
  logic [63:0] w_data;

  logic        a_rv, a_re, a_we, b_rv, b_re, b_we, c_rv, c_re, c_we;
  logic [31:0] a_rd, b_rd;
  logic [63:0] c_rd;
  logic [7:0]  a_ec, b_ec, c_ec;

  logic        ca_v, ca_e, cb_v, cb_e, cc_v, cc_e;
  logic [31:0] ca_d, cb_d;
  logic [63:0] cc_d;
  logic        wa_e, wb_e, wc_e;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  data_mem_lsu #(.MEM_A_WIDTH(8), .D_WIDTH(32), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_size(w_size),
    .w_data(w_data[31:0]), .w_err(a_we), .r_en(r_en), .r_addr(r_addr), .r_size(r_size),
    .r_uns(r_uns), .r_valid(a_rv), .r_data(a_rd), .r_err(a_re), .err_cnt(a_ec));

  data_mem_lsu #(.MEM_A_WIDTH(8), .D_WIDTH(32), .RD_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_size(w_size),
    .w_data(w_data[31:0]), .w_err(b_we), .r_en(r_en), .r_addr(r_addr), .r_size(r_size),
    .r_uns(r_uns), .r_valid(b_rv), .r_data(b_rd), .r_err(b_re), .err_cnt(b_ec));

  data_mem_lsu #(.MEM_A_WIDTH(8), .D_WIDTH(64), .RD_LAT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_size(w_size),
    .w_data(w_data), .w_err(c_we), .r_en(r_en), .r_addr(r_addr), .r_size(r_size),
    .r_uns(r_uns), .r_valid(c_rv), .r_data(c_rd), .r_err(c_re), .err_cnt(c_ec));

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] data;
    logic [63:0] exp;
    logic        exp_err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Starts just after a negedge; ends at a negedge with enables low.
  task automatic wr(input logic [31:0] addr, input logic [1:0] sz, input logic [63:0] data);
    w_en = 1'b1; w_addr = addr; w_size = sz; w_data = data;
    @(negedge clk);
    w_en = 1'b0;
    wa_e = a_we; wb_e = b_we; wc_e = c_we;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
    r_en = 1'b1; r_addr = addr; r_size = sz; r_uns = uns;
    @(negedge clk);
    r_en = 1'b0;
    ca_v = a_rv; ca_d = a_rd; ca_e = a_re;
    cc_v = c_rv; cc_d = c_rd; cc_e = c_re;
    @(negedge clk);
    cb_v = b_rv; cb_d = b_rd; cb_e = b_re;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h10,  SZ_W, 1'b0, 64'h8899AABB, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h13,  SZ_B, 1'b0, 64'h0, 64'hFFFFFF88, 1'b0};
    vecs[2]  = '{1'b0, 32'h13,  SZ_B, 1'b1, 64'h0, 64'h00000088, 1'b0};
    vecs[3]  = '{1'b0, 32'h11,  SZ_B, 1'b0, 64'h0, 64'hFFFFFFAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h20,  SZ_W, 1'b0, 64'hDEADBEEF, 64'h0, 1'b0};
    vecs[5]  = '{1'b1, 32'h22,  SZ_H, 1'b0, 64'h1234, 64'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h20,  SZ_W, 1'b0, 64'h0, 64'h1234BEEF, 1'b0};
    vecs[7]  = '{1'b0, 32'h20,  SZ_H, 1'b1, 64'h0, 64'h0000BEEF, 1'b0};
    vecs[8]  = '{1'b0, 32'h20,  SZ_H, 1'b0, 64'h0, 64'hFFFFBEEF, 1'b0};
    vecs[9]  = '{1'b0, 32'h22,  SZ_H, 1'b0, 64'h0, 64'h00001234, 1'b0};
    vecs[10] = '{1'b1, 32'h40,  SZ_W, 1'b0, 64'h11223344, 64'h0, 1'b0};
    vecs[11] = '{1'b1, 32'h04,  SZ_W, 1'b0, 64'hCAFEF00D, 64'h0, 1'b0};
    vecs[12] = '{1'b1, 32'h06,  SZ_W, 1'b0, 64'h55555555, 64'h0, 1'b1};
    vecs[13] = '{1'b0, 32'h04,  SZ_W, 1'b0, 64'h0, 64'hCAFEF00D, 1'b0};
    vecs[14] = '{1'b0, 32'h03,  SZ_H, 1'b0, 64'h0, 64'h0, 1'b1};
    vecs[15] = '{1'b1, 32'h08,  SZ_D, 1'b0, 64'h0123456789ABCDEF, 64'h0, 1'b1};
    vecs[16] = '{1'b0, 32'h08,  SZ_D, 1'b0, 64'h0, 64'h0, 1'b1};
    vecs[17] = '{1'b0, 32'h410, SZ_W, 1'b0, 64'h0, 64'h8899AABB, 1'b0};
    vecs[18] = '{1'b0, 32'h12,  SZ_B, 1'b1, 64'h0, 64'h00000099, 1'b0};
    vecs[19] = '{1'b1, 32'h05,  SZ_B, 1'b0, 64'hA5, 64'h0, 1'b0};
    vecs[20] = '{1'b0, 32'h04,  SZ_W, 1'b0, 64'h0, 64'hCAFEA50D, 1'b0};

    w_en = 1'b0; r_en = 1'b0; r_uns = 1'b0;
    w_addr = 32'h0; r_addr = 32'h0; w_size = SZ_B; r_size = SZ_B; w_data = 64'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst a_rv", a_rv, 64'h0);   chk("rst a_rd", a_rd, 64'h0);
    chk("rst a_we", a_we, 64'h0);   chk("rst a_ec", a_ec, 64'h0);
    chk("rst b_rv", b_rv, 64'h0);   chk("rst c_rd", c_rd, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].addr, vecs[i].size, vecs[i].data);
        chk($sformatf("v%0d a w_err", i), wa_e, 64'(vecs[i].exp_err));
        chk($sformatf("v%0d b w_err", i), wb_e, 64'(vecs[i].exp_err));
      end else begin
        rd(vecs[i].addr, vecs[i].size, vecs[i].uns);
        chk($sformatf("v%0d a r_valid", i), ca_v, 64'h1);
        chk($sformatf("v%0d a r_data", i), ca_d, vecs[i].exp);
        chk($sformatf("v%0d a r_err", i), ca_e, 64'(vecs[i].exp_err));
        chk($sformatf("v%0d b r_valid", i), cb_v, 64'h1);
        chk($sformatf("v%0d b r_data", i), cb_d, vecs[i].exp);
        chk($sformatf("v%0d b r_err", i), cb_e, 64'(vecs[i].exp_err));
      end
    end

    // w_err is a single-cycle pulse; faulting write leaves word 0x04 intact
    wr(32'h06, SZ_W, 64'h77777777);
    chk("pulse a w_err hi", wa_e, 64'h1);
    chk("pulse c w_err hi", wc_e, 64'h1);
    @(negedge clk);
    chk("pulse a w_err lo", a_we, 64'h0);
    rd(32'h04, SZ_W, 1'b0);
    chk("nowrite a r_data", ca_d, 64'hCAFEA50D);
    chk("err_cnt a", a_ec, 64'd5);
    chk("err_cnt b", b_ec, 64'd5);
    chk("err_cnt c", c_ec, 64'd3);

    // 64-bit configuration: dword round-trip and word extension
    rd(32'h08, SZ_D, 1'b0);
    chk("c dword valid", cc_v, 64'h1);
    chk("c dword err", cc_e, 64'h0);
    chk("c dword data", cc_d, 64'h0123456789ABCDEF);
    rd(32'h08, SZ_W, 1'b0);
    chk("c word sext", cc_d, 64'hFFFFFFFF89ABCDEF);
    rd(32'h0C, SZ_W, 1'b1);
    chk("c word zext", cc_d, 64'h0000000001234567);

    // Same-cycle write forwarding
    w_en = 1'b1; w_addr = 32'h41; w_size = SZ_B; w_data = 64'h5A;
    r_en = 1'b1; r_addr = 32'h40; r_size = SZ_W; r_uns = 1'b0;
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    chk("fwd a r_valid", a_rv, 64'h1);
    chk("fwd a r_data", a_rd, 64'h11225A44);
    chk("fwd c r_data", c_rd, 64'h0000000011225A44);
    @(negedge clk);
    chk("fwd b r_valid", b_rv, 64'h1);
    chk("fwd b r_data", b_rd, 64'h11225A44);

    // Read-at-issue: write in the cycle after r_en must not reach the RD_LAT=2 result
    r_en = 1'b1; r_addr = 32'h40; r_size = SZ_W; r_uns = 1'b0;
    @(negedge clk);
    r_en = 1'b0;
    w_en = 1'b1; w_addr = 32'h40; w_size = SZ_B; w_data = 64'h77;
    chk("rai a r_data", a_rd, 64'h11225A44);
    @(negedge clk);
    w_en = 1'b0;
    chk("rai b r_valid", b_rv, 64'h1);
    chk("rai b r_data", b_rd, 64'h11225A44);
    rd(32'h40, SZ_W, 1'b0);
    chk("rai after a", ca_d, 64'h11225A77);
    chk("rai after b", cb_d, 64'h11225A77);

    // Back-to-back reads with reset after the third
    r_en = 1'b1; r_addr = 32'h10; r_size = SZ_W; r_uns = 1'b0;
    @(negedge clk);
    chk("b2b a r0", a_rd, 64'h8899AABB);
    r_addr = 32'h20;
    @(negedge clk);
    chk("b2b b r0 valid", b_rv, 64'h1);
    chk("b2b b r0", b_rd, 64'h8899AABB);
    chk("b2b a r1", a_rd, 64'h1234BEEF);
    r_addr = 32'h04;
    @(negedge clk);
    r_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst b r_valid", b_rv, 64'h0);
    chk("rst b r_data", b_rd, 64'h0);
    chk("rst a r_valid", a_rv, 64'h0);
    chk("rst a err_cnt", a_ec, 64'h0);
    chk("rst b err_cnt", b_ec, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    r_en = 1'b1; r_addr = 32'h40; r_size = SZ_W;
    @(negedge clk);
    r_en = 1'b0;
    chk("post b no stale", b_rv, 64'h0);
    chk("post a r_data", a_rd, 64'h11225A77);
    @(negedge clk);
    chk("post b r_valid", b_rv, 64'h1);
    chk("post b r_data", b_rd, 64'h11225A77);
    @(negedge clk);
    chk("post b drained", b_rv, 64'h0);

    // Simultaneous write and read fault adds 2
    w_en = 1'b1; w_addr = 32'h06; w_size = SZ_W; w_data = 64'h0;
    r_en = 1'b1; r_addr = 32'h03; r_size = SZ_H;
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    chk("dbl a err_cnt", a_ec, 64'd2);
    chk("dbl c err_cnt", c_ec, 64'd2);
    chk("dbl a w_err", a_we, 64'h1);
    chk("dbl a r_err", a_re, 64'h1);
    chk("dbl a r_data", a_rd, 64'h0);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      r_en = 1'b1; r_addr = 32'h01; r_size = SZ_H;
      @(negedge clk);
      if (i == 99) chk("sat mid a", a_ec, 64'd102);
    end
    r_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("sat a", a_ec, 64'd255);
    chk("sat b", b_ec, 64'd255);
    chk("sat c", c_ec, 64'd255);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
